// File: rtl/fir_sum_stage.sv
// Eight-tap FIR summation back end: registered unsigned adder tree, then
// shift/saturate to a 16-bit result with a sticky saturation flag and a sample counter.
module fir_sum_stage #(
  parameter int NTAPS = 8,
  parameter int SHIFT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [NTAPS*32-1:0]    tap_bus,
  input  logic                   clr_flag,
  output logic [34:0]            sum_out,
  output logic [15:0]            y_out,
  output logic                   valid_out,
  output logic                   sat_flag,
  output logic [15:0]            sample_count
);

  localparam int NPAIR = NTAPS / 2;
  localparam int NQUAD = NTAPS / 4;

  // Valid-only flow (no ready): a stage loads its data when the valid
  // arriving from the previous stage is 1 and holds otherwise; its valid bit
  // simply follows the upstream valid one cycle later, so every cycle may carry data.

  logic                  s0_valid_q, s0_valid_d;
  logic [NTAPS*32-1:0]   s0_taps_q,  s0_taps_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [32:0]           s1_sum_q [NPAIR];
  logic [32:0]           s1_sum_d [NPAIR];
  logic                  s2_valid_q, s2_valid_d;
  logic [33:0]           s2_sum_q [NQUAD];
  logic [33:0]           s2_sum_d [NQUAD];
  logic                  s3_valid_q, s3_valid_d;
  logic [34:0]           s3_sum_q,   s3_sum_d;

  logic                  valid_out_q,    valid_out_d;
  logic [34:0]           sum_out_q,      sum_out_d;
  logic [15:0]           y_out_q,        y_out_d;
  logic                  sat_flag_q,     sat_flag_d;
  logic [15:0]           sample_count_q, sample_count_d;

  logic [34:0]           shifted;
  logic                  over_range;
  logic                  sat_hit;
  logic [15:0]           y_sat;

  always_comb begin
    s0_valid_d = valid_in;
    s0_taps_d  = valid_in ? tap_bus : s0_taps_q;

    s1_valid_d = s0_valid_q;
    for (int k = 0; k < NPAIR; k++) begin
      s1_sum_d[k] = s1_sum_q[k];
      if (s0_valid_q)
        s1_sum_d[k] = {1'b0, s0_taps_q[64*k +: 32]} + {1'b0, s0_taps_q[64*k+32 +: 32]};
    end

    s2_valid_d = s1_valid_q;
    for (int k = 0; k < NQUAD; k++) begin
      s2_sum_d[k] = s2_sum_q[k];
      if (s1_valid_q)
        s2_sum_d[k] = {1'b0, s1_sum_q[2*k]} + {1'b0, s1_sum_q[2*k+1]};
    end

    s3_valid_d = s2_valid_q;
    s3_sum_d   = s2_valid_q ? ({1'b0, s2_sum_q[0]} + {1'b0, s2_sum_q[1]}) : s3_sum_q;

    // Truncating shift; anything left above bit 15 clamps to full scale.
    shifted    = s3_sum_q >> SHIFT;
    over_range = |shifted[34:16];
    y_sat      = over_range ? 16'hFFFF : shifted[15:0];
    sat_hit    = s3_valid_q && over_range;

    valid_out_d    = s3_valid_q;
    sum_out_d      = s3_valid_q ? s3_sum_q : sum_out_q;
    y_out_d        = s3_valid_q ? y_sat : y_out_q;
    sat_flag_d     = sat_hit | (sat_flag_q & ~clr_flag);
    sample_count_d = s3_valid_q ? sample_count_q + 16'd1 : sample_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q     <= 1'b0;
      s0_taps_q      <= '0;
      s1_valid_q     <= 1'b0;
      for (int k = 0; k < NPAIR; k++) s1_sum_q[k] <= '0;
      s2_valid_q     <= 1'b0;
      for (int k = 0; k < NQUAD; k++) s2_sum_q[k] <= '0;
      s3_valid_q     <= 1'b0;
      s3_sum_q       <= '0;
      valid_out_q    <= 1'b0;
      sum_out_q      <= '0;
      y_out_q        <= '0;
      sat_flag_q     <= 1'b0;
      sample_count_q <= '0;
    end else begin
      s0_valid_q     <= s0_valid_d;
      s0_taps_q      <= s0_taps_d;
      s1_valid_q     <= s1_valid_d;
      for (int k = 0; k < NPAIR; k++) s1_sum_q[k] <= s1_sum_d[k];
      s2_valid_q     <= s2_valid_d;
      for (int k = 0; k < NQUAD; k++) s2_sum_q[k] <= s2_sum_d[k];
      s3_valid_q     <= s3_valid_d;
      s3_sum_q       <= s3_sum_d;
      valid_out_q    <= valid_out_d;
      sum_out_q      <= sum_out_d;
      y_out_q        <= y_out_d;
      sat_flag_q     <= sat_flag_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign valid_out    = valid_out_q;
  assign sum_out      = sum_out_q;
  assign y_out        = y_out_q;
  assign sat_flag     = sat_flag_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_fir_sum_stage.sv
// Directed bench for fir_sum_stage: one instance with SHIFT=15, one with SHIFT=0,
// both fed the same stimulus; expected values are hand-computed constants.
module tb_fir_sum_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [255:0] tap_bus;
  logic         clr_flag;

  logic [34:0]  sum15, sum0;
  logic [15:0]  y15, y0, cnt15, cnt0;
  logic         v15, v0, sat15, sat0;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  logic [15:0]  exp_q[$];
  logic [15:0]  exp_hold;

  localparam logic [255:0] TAPS_8000 = {8{32'h0000_8000}};
  localparam logic [255:0] TAPS_FULL = {8{32'hFFFF_FFFF}};

  always #5 clk = ~clk;

  fir_sum_stage #(.NTAPS(8), .SHIFT(15)) dut15 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .tap_bus(tap_bus), .clr_flag(clr_flag),
    .sum_out(sum15), .y_out(y15), .valid_out(v15), .sat_flag(sat15), .sample_count(cnt15)
  );

  fir_sum_stage #(.NTAPS(8), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .tap_bus(tap_bus), .clr_flag(clr_flag),
    .sum_out(sum0), .y_out(y0), .valid_out(v0), .sat_flag(sat0), .sample_count(cnt0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [255:0] taps);
    valid_in = v;
    tap_bus  = taps;
    tick();
  endtask

  function automatic logic [255:0] junk();
    return {8{$urandom()}};
  endfunction

  initial begin
    rst      = 1'b1;
    valid_in = 1'b1;
    tap_bus  = TAPS_FULL;
    clr_flag = 1'b0;

    // Reset holds everything at zero even with valid_in asserted.
    repeat (3) tick();
    check("rst_valid", v15, 0);
    check("rst_sum", sum15, 0);
    check("rst_y", y15, 0);
    check("rst_sat", sat15, 0);
    check("rst_cnt", cnt15, 0);
    rst      = 1'b0;
    valid_in = 1'b0;

    // Basic sum: 8 * 0x8000 = 262144, >>15 = 8.
    drive(1'b1, TAPS_8000);
    repeat (3) drive(1'b0, junk());
    check("lat_early", v15, 0);
    drive(1'b0, junk());
    check("basic_valid", v15, 1);
    check("basic_sum", sum15, 64'd262144);
    check("basic_y", y15, 8);
    check("basic_sat", sat15, 0);
    check("basic_cnt", cnt15, 1);
    drive(1'b0, junk());
    check("basic_pulse", v15, 0);
    check("basic_hold", y15, 8);

    // Saturation, then a non-saturating input keeps the sticky flag.
    drive(1'b1, TAPS_FULL);
    repeat (4) drive(1'b0, junk());
    check("sat_valid", v15, 1);
    check("sat_sum", sum15, 64'd34359738360);
    check("sat_y", y15, 65535);
    check("sat_flag", sat15, 1);
    check("sat_cnt", cnt15, 2);
    drive(1'b1, TAPS_8000);
    repeat (4) drive(1'b0, junk());
    check("sticky_y", y15, 8);
    check("sticky_flag", sat15, 1);
    check("sticky_cnt", cnt15, 3);

    // clr_flag on the saturating edge loses; on a later edge it clears.
    drive(1'b1, TAPS_FULL);
    repeat (3) drive(1'b0, junk());
    clr_flag = 1'b1;
    drive(1'b0, junk());
    check("clr_coll_valid", v15, 1);
    check("clr_coll_flag", sat15, 1);
    drive(1'b0, junk());
    check("clr_later_flag", sat15, 0);
    clr_flag = 1'b0;
    drive(1'b0, junk());
    check("clr_stays", sat15, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_cnt", cnt0, 0);

    // Back-to-back on the SHIFT=0 instance: tap0 = 1..5.
    exp_hold = 16'd0;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) exp_q.push_back(16'(c + 1));
      drive(c < 5, (c < 5) ? 256'(c + 1) : 256'(0));
      check("b2b_valid", v0, (c >= 4 && c <= 8) ? 1 : 0);
      if (c >= 4 && c <= 8 && exp_q.size() > 0) exp_hold = exp_q.pop_front();
      check("b2b_y", y0, exp_hold);
    end
    check("b2b_cnt", cnt0, 5);
    check("b2b_drained", exp_q.size(), 0);

    // Bubbles 1,0,0,1 with junk on idle cycles; y_out must hold in the gap.
    for (int c = 0; c < 9; c++) begin
      logic v;
      logic exp_v;
      logic [15:0] val;
      v     = (c == 0) || (c == 3);
      exp_v = (c == 4) || (c == 7);
      val   = (c == 0) ? 16'd7 : 16'd9;
      if (v) exp_q.push_back(val);
      drive(v, v ? 256'(val) : junk());
      check("bub_valid", v0, exp_v);
      if (exp_v && exp_q.size() > 0) exp_hold = exp_q.pop_front();
      check("bub_y", y0, exp_hold);
    end
    check("bub_cnt", cnt0, 7);

    // Reset one cycle after the third of three accepted inputs.
    repeat (3) drive(1'b1, 256'(3));
    drive(1'b0, junk());
    rst = 1'b1;
    #1;
    check("midrst_valid", v0, 0);
    check("midrst_sum", sum0, 0);
    check("midrst_y", y0, 0);
    check("midrst_cnt", cnt0, 0);
    check("midrst_sat", sat0, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, junk());
      check("midrst_no_pulse0", v0, 0);
      check("midrst_no_pulse15", v15, 0);
    end
    check("midrst_cnt_end", cnt0, 0);
    check("midrst_y_end", y0, 0);
    check("midrst_sum_end", sum15, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_sum_stage.md
FIR_SUM_STAGE -- requirements
Module: fir_sum_stage

Interface
REQ-001 SHALL have parameter NTAPS, default 8, number of tap products summed; only 8 is supported.
REQ-002 SHALL have parameter SHIFT, default 15, right-shift applied to the full sum before output saturation; legal range 0..19.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  tap_bus holds one valid set of tap products this cycle.
REQ-006 SHALL have port tap_bus  input  256  8 unsigned 32-bit tap products; tap k at bits [32k+31:32k].
REQ-007 SHALL have port clr_flag  input  1  synchronous clear of sat_flag.
REQ-008 SHALL have port sum_out  output  35  full-precision unsigned sum of the 8 taps.
REQ-009 SHALL have port y_out  output  16  (sum >> SHIFT), saturated to 16-bit unsigned.
REQ-010 SHALL have port valid_out  output  1  one-cycle pulse; sum_out and y_out valid.
REQ-011 SHALL have port sat_flag  output  1  sticky; at least one output saturated since last clear.
REQ-012 SHALL have port sample_count  output  16  number of valid_out pulses since reset, wrapping.

Function
REQ-013 SHALL treat all tap products and sums as unsigned; no sign extension anywhere.
REQ-014 SHALL implement a registered adder tree: stage 1 = 4 pairwise sums (33 bit), stage 2 = 2 sums (34 bit), stage 3 = 1 sum (35 bit), stage 4 = shift/saturate and output register.
REQ-015 SHALL carry a valid bit alongside each stage; a stage's data registers load only when its incoming valid is 1, otherwise hold.
REQ-016 SHALL assert valid_out exactly 4 cycles after the edge that samples valid_in=1 (sample at edge N, valid_out high after edge N+4).
REQ-017 SHALL accept valid_in=1 on every cycle (full throughput); each accepted input produces exactly one valid_out pulse, in order.
REQ-018 SHALL hold sum_out and y_out stable between valid_out pulses (last result retained).
REQ-019 SHALL compute y_out = sum >> SHIFT (truncation, no rounding) when that value <= 65535, else 65535.
REQ-020 SHALL set sat_flag on the same edge as the valid_out pulse whose y_out saturated.
REQ-021 SHALL clear sat_flag on an edge where clr_flag=1, except that a saturation on that same edge sets it (set wins).
REQ-022 SHALL increment sample_count on every edge that raises valid_out, wrapping 65535 -> 0.
REQ-023 SHALL never overflow the 35-bit sum: maximum 8*(2^32-1) = 34359738360 < 2^35.

Reset
REQ-024 SHALL, on rst=1, immediately clear all stage valid bits, valid_out, sat_flag, sample_count, sum_out and y_out to 0.
REQ-025 SHALL discard any results in flight when rst asserts; no valid_out pulse from inputs accepted before reset.
REQ-026 SHALL ignore valid_in while rst=1; the first input accepted is on the first edge with rst=0.

Verification
REQ-027 SHALL cover basic sum: SHIFT=15, all 8 taps = 0x00008000, one valid_in pulse -> 4 cycles later valid_out=1, sum_out=262144, y_out=8, sat_flag=0, sample_count=1.
REQ-028 SHALL cover saturation: all taps = 0xFFFFFFFF -> sum_out=34359738360, y_out=65535, sat_flag=1 and stays 1 after further non-saturating inputs.
REQ-029 SHALL cover back-to-back: 5 consecutive valid_in cycles with tap0 = 1..5 (others 0), SHIFT=0 -> 5 consecutive valid_out pulses, y_out 1,2,3,4,5 in order, sample_count ends at 5.
REQ-030 SHALL cover bubbles: valid_in pattern 1,0,0,1 -> valid_out pattern 1,0,0,1 delayed 4 cycles; y_out holds first result during gap.
REQ-031 SHALL cover clr_flag collision: clr_flag=1 on the same edge as a saturating valid_out -> sat_flag=1; clr_flag=1 on a later non-saturating edge -> sat_flag=0.
REQ-032 SHALL cover reset mid-operation: 3 valid inputs then rst pulse 1 cycle after the last -> no valid_out ever appears for them, all outputs 0, sample_count=0.
